// File: rtl/mdu_scheduler.sv
// mdu_scheduler: multiply/divide resource controller for the EX stage.
// Accepts mult/multu/div/divu/mthi/mtlo, runs multi-cycle operations under a
// busy counter, owns the HI/LO registers and serves mfhi/mflo reads.
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous active-high reset
//   op_valid   EX holds an MDU write-class instruction
//   op         0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6-7 no-op
//   rs_val     rs operand (dividend / multiplicand / mthi-mtlo source)
//   rt_val     rt operand (divisor / multiplier)
//   rd_req     EX holds mfhi/mflo
//   rd_sel     0 selects LO, 1 selects HI
//   rd_data    committed HI or LO per rd_sel
//   busy       operation in flight
//   stall_req  busy & (op_valid | rd_req)
//   hi, lo     architectural HI/LO
module mdu_scheduler #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        rd_req,
  input  logic        rd_sel,
  output logic [31:0] rd_data,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic {StIdle, StRun} state_e;

  localparam logic [2:0] OpMult  = 3'd0;
  localparam logic [2:0] OpMultu = 3'd1;
  localparam logic [2:0] OpDiv   = 3'd2;
  localparam logic [2:0] OpDivu  = 3'd3;
  localparam logic [2:0] OpMthi  = 3'd4;
  localparam logic [2:0] OpMtlo  = 3'd5;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic        busy_q;
  logic [31:0] hi_q, lo_q;
  logic [31:0] pend_hi_q, pend_lo_q;
  logic        pend_wr_q;

  // Result of the operation presented on the inputs, captured at issue.
  logic [63:0] res;
  logic        res_wr;
  logic [63:0] rs_sx, rt_sx, rs_zx, rt_zx;
  logic [31:0] dvd_abs, dvs_abs, dvs_safe, q_u, r_u, q, r;
  logic        is_signed;

  always_comb begin
    res       = '0;
    res_wr    = 1'b1;
    rs_sx     = {{32{rs_val[31]}}, rs_val};
    rt_sx     = {{32{rt_val[31]}}, rt_val};
    rs_zx     = {32'd0, rs_val};
    rt_zx     = {32'd0, rt_val};
    is_signed = (op == OpDiv);
    dvd_abs   = (is_signed && rs_val[31]) ? (~rs_val + 32'd1) : rs_val;
    dvs_abs   = (is_signed && rt_val[31]) ? (~rt_val + 32'd1) : rt_val;
    // Substitute 1 for a zero divisor so the divider never sees /0; the
    // result is discarded anyway.
    dvs_safe  = (dvs_abs == 32'd0) ? 32'd1 : dvs_abs;
    q_u       = dvd_abs / dvs_safe;
    r_u       = dvd_abs % dvs_safe;
    q         = (is_signed && (rs_val[31] ^ rt_val[31])) ? (~q_u + 32'd1) : q_u;
    r         = (is_signed && rs_val[31]) ? (~r_u + 32'd1) : r_u;
    unique case (op)
      OpMult:  res = rs_sx * rt_sx;
      OpMultu: res = rs_zx * rt_zx;
      OpDiv, OpDivu: begin
        res    = {r, q};
        res_wr = (rt_val != 32'd0);
      end
      default: begin
        res    = '0;
        res_wr = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_wr_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (op_valid) begin
            unique case (op)
              OpMult, OpMultu, OpDiv, OpDivu: begin
                pend_hi_q <= res[63:32];
                pend_lo_q <= res[31:0];
                pend_wr_q <= res_wr;
                cnt_q     <= (op == OpMult || op == OpMultu) ? 4'(MULT_CYCLES)
                                                             : 4'(DIV_CYCLES);
                busy_q    <= 1'b1;
                state_q   <= StRun;
              end
              OpMthi:  hi_q <= rs_val;
              OpMtlo:  lo_q <= rs_val;
              default: ;
            endcase
          end
        end
        StRun: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            if (pend_wr_q) begin
              hi_q <= pend_hi_q;
              lo_q <= pend_lo_q;
            end
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // No bypass: reads always see committed HI/LO.
  assign rd_data   = rd_sel ? hi_q : lo_q;
  assign busy      = busy_q;
  assign stall_req = busy_q & (op_valid | rd_req);
  assign hi        = hi_q;
  assign lo        = lo_q;

endmodule
